fixed_mac_pipe: RTL and testbench

- Pipelined signed N.M fixed-point multiply-accumulate unit for the CNN datapath. Successor to the combinational fixed-point multiplier.
- Adds parametrised rounding, saturation with an overflow flag, multi-beat dot-product accumulation, and valid/ready flow control with backpressure.
- Sits between the weight/activation fetch logic and the layer output buffers. A single-beat item gives a plain registered multiply.

---
 rtl/fixed_mac_pipe.sv | 127 ++++++++++++
 tb/tb_fixed_mac_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_pipe.sv
// Pipelined signed N.M fixed-point multiply-accumulate with rounding, saturation,
// multi-beat dot-product accumulation and valid/ready flow control.
module fixed_mac_pipe #(
  parameter int N     = 4,
  parameter int M     = 23,
  parameter int GUARD = 8,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N+M-1:0]   a,
  input  logic [N+M-1:0]   b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   out,
  output logic             ovf
);

  localparam int W     = N + M;
  localparam int PW    = 2 * W;
  localparam int SW    = W + N;
  localparam int ACC_W = W + N + GUARD;

  localparam logic signed [PW-1:0]    RND_ADD = (ROUND != 0) ? (PW'(1) << (M - 1)) : '0;
  localparam logic signed [ACC_W-1:0] MAX_V   = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V   = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic                    w_en;
  logic signed [PW-1:0]    w_a_ext;
  logic signed [PW-1:0]    w_b_ext;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_rsum;
  logic signed [SW-1:0]    w_s;
  logic signed [ACC_W-1:0] w_s_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_hi;
  logic                    w_lo;
  logic [W-1:0]            w_out_d;
  logic                    w_unused_lsbs;

  logic signed [PW-1:0]    r_p1;
  logic                    r_v1;
  logic                    r_f1;
  logic                    r_l1;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic                    r_ovf;
  logic [W-1:0]            r_out;

  // Handshake: a beat transfers when in_valid & in_ready; a result transfers when
  // out_valid & out_ready. The whole pipeline advances only when the output
  // register is empty or being drained, so a stalled result freezes every stage.
  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;

  assign w_a_ext = {{W{a[W-1]}}, a};
  assign w_b_ext = {{W{b[W-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Top SW bits of the rounded product are the arithmetic shift right by M.
  assign w_rsum        = r_p1 + RND_ADD;
  assign w_s           = w_rsum[PW-1:M];
  assign w_unused_lsbs = ^w_rsum[M-1:0];
  assign w_s_ext       = {{(ACC_W-SW){w_s[SW-1]}}, w_s};
  assign w_acc_next    = r_f1 ? w_s_ext : (r_acc + w_s_ext);

  assign w_hi = (w_acc_next > MAX_V);
  assign w_lo = (w_acc_next < MIN_V);

  always_comb begin
    w_out_d = w_acc_next[W-1:0];
    if (SAT != 0) begin
      if (w_hi) begin
        w_out_d = MAX_V[W-1:0];
      end else if (w_lo) begin
        w_out_d = MIN_V[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1 <= '0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      r_l1 <= 1'b0;
    end else if (w_en) begin
      r_p1 <= w_prod;
      r_v1 <= in_valid;
      r_f1 <= in_first;
      r_l1 <= in_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_en && r_v1) begin
      r_acc <= w_acc_next;
    end
  end

  // out/ovf only change on a last beat so they stay meaningful between sums.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_out       <= '0;
    end else if (w_en) begin
      r_out_valid <= r_v1 & r_l1;
      if (r_v1 && r_l1) begin
        r_ovf <= w_hi | w_lo;
        r_out <= w_out_d;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fixed_mac_pipe.sv
// Bench for fixed_mac_pipe: a default (round/saturate) and a legacy (floor/wrap)
// instance share stimulus; results are scored against an arithmetic model.
module tb_fixed_mac_pipe;

  localparam int N = 4;
  localparam int M = 23;
  localparam int W = N + M;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp_d;
    logic [W:0]   exp_l;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_first, in_last, out_ready;
  logic [W-1:0] a, b;
  logic in_ready_d, out_valid_d, ovf_d;
  logic [W-1:0] out_d;
  logic in_ready_l, out_valid_l, ovf_l;
  logic [W-1:0] out_l;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  bit rand_ready = 1'b0;
  longint m_acc_d = 0;
  longint m_acc_l = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_l_q[$];
  logic [W:0] e_d, e_l;
  vec_t vecs[7];

  always #5 clk = ~clk;

  fixed_mac_pipe #(.N(N), .M(M), .GUARD(8), .ROUND(1), .SAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid_d), .out_ready(out_ready), .out(out_d), .ovf(ovf_d)
  );

  fixed_mac_pipe #(.N(N), .M(M), .GUARD(8), .ROUND(0), .SAT(0)) dut_legacy (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid_l), .out_ready(out_ready), .out(out_l), .ovf(ovf_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, optional half-LSB bias, floor to M fraction bits.
  function automatic longint scale(input logic [W-1:0] x, input logic [W-1:0] y, input bit rnd);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    if (rnd) p = p + (longint'(1) << (M - 1));
    return p >>> M;
  endfunction

  function automatic logic [W:0] result(input longint acc, input bit sat);
    logic   ov;
    longint v;
    ov = (acc > MAXV) || (acc < MINV);
    v  = acc;
    if (sat && acc > MAXV) v = MAXV;
    else if (sat && acc < MINV) v = MINV;
    return {ov, v[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       v = W'($urandom());
      1:       v = W'($urandom_range(0, 16)) - W'(8);
      2:       v = ($urandom_range(0, 1) != 0) ? 27'h4000000 : 27'h3FFFFFF;
      default: v = W'($urandom_range(0, 32'h01000000));
    endcase
    return v;
  endfunction

  task automatic push_exp(input logic [W:0] ed, input logic [W:0] el);
    exp_q.push_back(ed);
    exp_l_q.push_back(el);
  endtask

  task automatic model_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tf, input logic tl);
    longint sd, sl;
    sd = scale(ta, tb, 1'b1);
    sl = scale(ta, tb, 1'b0);
    m_acc_d = tf ? sd : m_acc_d + sd;
    m_acc_l = tf ? sl : m_acc_l + sl;
    if (tl) push_exp(result(m_acc_d, 1'b1), result(m_acc_l, 1'b0));
  endtask

  // Drives one beat and returns just after the edge that accepts it.
  task automatic send_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tf, input logic tl);
    int n;
    n = 0;
    a = ta; b = tb; in_first = tf; in_last = tl; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_d && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_d) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tf, input logic tl);
    model_beat(ta, tb, tf, tl);
    send_beat(ta, tb, tf, tl);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_l_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: one comparison per output transfer.
  always @(negedge clk) begin
    if (!reset && out_valid_d && out_ready) begin
      n_xfer++;
      check("legacy_valid", 64'(out_valid_l), 64'd1);
      if (exp_q.size() == 0 || exp_l_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h with no expected entry", out_d);
      end else begin
        e_d = exp_q.pop_front();
        e_l = exp_l_q.pop_front();
        check("out", 64'(out_d), 64'(e_d[W-1:0]));
        check("ovf", 64'(ovf_d), 64'(e_d[W]));
        check("legacy_out", 64'(out_l), 64'(e_l[W-1:0]));
        check("legacy_ovf", 64'(ovf_l), 64'(e_l[W]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int x0;
    logic [W-1:0] co;
    logic cov;

    vecs[0] = '{"mul_1p5_0p875", 27'h0C00000, 27'h0700000, {1'b0, 27'h0A80000}, {1'b0, 27'h0A80000}};
    vecs[1] = '{"sat_pos",       27'h3C00000, 27'h1800000, {1'b1, 27'h3FFFFFF}, {1'b1, 27'h3400000}};
    vecs[2] = '{"sat_neg",       27'h4000000, 27'h1000000, {1'b1, 27'h4000000}, {1'b1, 27'h0000000}};
    vecs[3] = '{"round_pos",     27'h0000001, 27'h0400000, {1'b0, 27'h0000001}, {1'b0, 27'h0000000}};
    vecs[4] = '{"round_neg",     27'h7FFFFFF, 27'h0400000, {1'b0, 27'h0000000}, {1'b0, 27'h7FFFFFF}};
    vecs[5] = '{"mul_neg",       27'h7C00000, 27'h0400000, {1'b0, 27'h7E00000}, {1'b0, 27'h7E00000}};
    vecs[6] = '{"min_squared",   27'h4000000, 27'h4000000, {1'b1, 27'h3FFFFFF}, {1'b1, 27'h0000000}};

    reset = 1'b1; out_ready = 1'b1; a = '0; b = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid_d), 64'd0);
    check("reset_out", 64'(out_d), 64'd0);
    check("reset_ovf", 64'(ovf_d), 64'd0);
    check("reset_in_ready", 64'(in_ready_d), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency: accepted at edge k, visible only after edge k+1.
    push_exp({1'b0, 27'h0A80000}, {1'b0, 27'h0A80000});
    send_beat(27'h0C00000, 27'h0700000, 1'b1, 1'b1);
    idle();
    check("latency_k", 64'(out_valid_d), 64'd0);
    @(posedge clk);
    #1;
    check("latency_k1", 64'(out_valid_d), 64'd1);
    wait_drain();

    for (int i = 0; i < 7; i++) begin
      push_exp(vecs[i].exp_d, vecs[i].exp_l);
      send_beat(vecs[i].a, vecs[i].b, 1'b1, 1'b1);
    end
    idle();
    wait_drain();

    // Three-beat dot product, back to back: one result only.
    x0 = n_xfer;
    push_exp({1'b0, 27'h2880000}, {1'b0, 27'h2880000});
    send_beat(27'h0C00000, 27'h0700000, 1'b1, 1'b0);
    send_beat(27'h7C00000, 27'h0400000, 1'b0, 1'b0);
    send_beat(27'h1000000, 27'h1000000, 1'b0, 1'b1);
    idle();
    wait_drain();
    check("dot_pulses", 64'(n_xfer - x0), 64'd1);

    // Backpressure with a continuous input stream.
    x0 = n_xfer;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) beat(rand_op(), rand_op(), 1'b1, 1'b1);
        idle();
      end
      begin
        for (int n = 0; n < 20 && !out_valid_d; n++) @(negedge clk);
        check("bp_valid", 64'(out_valid_d), 64'd1);
        co = out_d;
        cov = ovf_d;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready_d), 64'd0);
          check("bp_in_valid_held", 64'(in_valid), 64'd1);
          check("bp_out_stable", 64'(out_d), 64'(co));
          check("bp_ovf_stable", 64'(ovf_d), 64'(cov));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_count", 64'(n_xfer - x0), 64'd5);

    // Async reset mid-sum while a stale ovf is held.
    beat(27'h3C00000, 27'h1800000, 1'b1, 1'b1);
    beat(27'h0800000, 27'h0800000, 1'b1, 1'b0);
    beat(27'h0800000, 27'h0800000, 1'b0, 1'b0);
    idle();
    #2;
    check("pre_reset_ovf", 64'(ovf_d), 64'd1);
    reset = 1'b1;
    m_acc_d = 0; m_acc_l = 0;
    #1;
    check("async_out_valid", 64'(out_valid_d), 64'd0);
    check("async_ovf", 64'(ovf_d), 64'd0);
    check("async_legacy_ovf", 64'(ovf_l), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp({1'b0, 27'h0700000}, {1'b0, 27'h0700000});
    send_beat(27'h0700000, 27'h0800000, 1'b1, 1'b1);
    idle();
    wait_drain();

    // Reset while a result is stalled, then a sum with no first flag starts from 0.
    out_ready = 1'b0;
    send_beat(27'h0800000, 27'h0800000, 1'b1, 1'b1);
    idle();
    @(posedge clk);
    #1;
    check("stall_valid", 64'(out_valid_d), 64'd1);
    #2;
    reset = 1'b1;
    m_acc_d = 0; m_acc_l = 0;
    #1;
    check("async_out_valid2", 64'(out_valid_d), 64'd0);
    check("async_out2", 64'(out_d), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    beat(27'h0C00000, 27'h0400000, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Random framing, operands, gaps and backpressure.
    rand_ready = 1'b1;
    beat(rand_op(), rand_op(), 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      beat(rand_op(), rand_op(), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    beat(rand_op(), rand_op(), 1'b0, 1'b1);
    idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
